// File: rtl/ov_7670_pkg.sv
// Shared constants for the OV7670 stream emulator: FSM state codes, pattern codes,
// colour-bar palette and LFSR parameters (used when OV7670_STREAM_GEN_LFSR_EN is defined).
package ov_7670_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VSYNC  = 3'd1;
    localparam state_t ST_VBACK  = 3'd2;
    localparam state_t ST_ACTIVE = 3'd3;
    localparam state_t ST_VFRONT = 3'd4;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_COORD = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    localparam logic [15:0] BAR_0 = 16'hFFFF;
    localparam logic [15:0] BAR_1 = 16'hFFE0;
    localparam logic [15:0] BAR_2 = 16'h07FF;
    localparam logic [15:0] BAR_3 = 16'h07E0;
    localparam logic [15:0] BAR_4 = 16'hF81F;
    localparam logic [15:0] BAR_5 = 16'hF800;
    localparam logic [15:0] BAR_6 = 16'h001F;
    localparam logic [15:0] BAR_7 = 16'h0000;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_0;
            3'd1:    c = BAR_1;
            3'd2:    c = BAR_2;
            3'd3:    c = BAR_3;
            3'd4:    c = BAR_4;
            3'd5:    c = BAR_5;
            3'd6:    c = BAR_6;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/ov_7670_pattern_gen.sv
// Test-pattern source: maps pattern code, pixel and line index to an RGB565 pixel.
// The LFSR pattern exists only when OV7670_STREAM_GEN_LFSR_EN is defined.
module ov_7670_pattern_gen
    import ov_7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter logic [15:0] SOLID_COLOR = 16'h07E0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  line,
    input  logic        seed_load,
    input  logic        step,
    output logic [15:0] pixel
);

    localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [9:0] bar_q;
    logic [2:0] bar_idx;

    assign bar_q   = h_cnt / 10'(BAR_W);
    assign bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];

`ifdef OV7670_STREAM_GEN_LFSR_EN
    logic [15:0] lfsr;
    logic [1:0]  unused_line;

    assign unused_line = line[9:8];

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, reset, seed_load, step, line[9:8]};
`endif

    always_comb begin
        pixel = SOLID_COLOR;
        case (sel)
            PAT_BARS:  pixel = bar_color(bar_idx);
            PAT_COORD: pixel = {line[7:0], h_cnt[7:0]};
            PAT_SOLID: pixel = SOLID_COLOR;
            default: begin
`ifdef OV7670_STREAM_GEN_LFSR_EN
                pixel = lfsr;
`else
                pixel = SOLID_COLOR;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ov_7670_stream_gen.sv
// OV7670 camera emulator: PCLK/VSYNC/HREF/D[7:0] RGB565 stream from on-chip patterns.
// Optional LFSR pattern is enabled by defining OV7670_STREAM_GEN_LFSR_EN.
module ov_7670_stream_gen
    import ov_7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter logic [15:0] SOLID_COLOR = 16'h07E0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [9:0]  VS_LAST = 10'(VSYNC_LINES - 1);
    localparam logic [9:0]  VB_LAST = 10'(V_BACK - 1);
    localparam logic [9:0]  VA_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VF_LAST = 10'(V_FRONT - 1);

    state_t      state, nxt_state;
    logic        byte_sel, nxt_byte;
    logic [9:0]  h_cnt, v_cnt, nxt_h, nxt_v, v_last;
    logic [1:0]  sel_q;
    logic        start_frame, nxt_active, last_h, line_last, frame_end;
    logic        lfsr_seed, lfsr_step;
    logic [15:0] pixel;

    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VS_LAST;
            ST_VBACK:  v_last = VB_LAST;
            ST_ACTIVE: v_last = VA_LAST;
            ST_VFRONT: v_last = VF_LAST;
            default:   v_last = '0;
        endcase
    end

    assign last_h    = (h_cnt == H_LAST);
    assign line_last = byte_sel && last_h && (v_cnt == v_last);
    assign frame_end = (state == ST_VFRONT) && line_last;

    // Position of the byte slot that starts at the next phase-0 entry.
    always_comb begin
        nxt_state   = state;
        nxt_byte    = ~byte_sel;
        nxt_h       = h_cnt;
        nxt_v       = v_cnt;
        start_frame = 1'b0;
        if (state == ST_IDLE) begin
            nxt_byte = 1'b0;
            nxt_h    = '0;
            nxt_v    = '0;
            if (enable) begin
                nxt_state   = ST_VSYNC;
                start_frame = 1'b1;
            end
        end else if (byte_sel && last_h) begin
            nxt_h = '0;
            if (v_cnt == v_last) begin
                nxt_v = '0;
                case (state)
                    ST_VSYNC:  nxt_state = ST_VBACK;
                    ST_VBACK:  nxt_state = ST_ACTIVE;
                    ST_ACTIVE: nxt_state = ST_VFRONT;
                    default: begin
                        if (enable) begin
                            nxt_state   = ST_VSYNC;
                            start_frame = 1'b1;
                        end else begin
                            nxt_state = ST_IDLE;
                        end
                    end
                endcase
            end else begin
                nxt_v = v_cnt + 10'd1;
            end
        end else if (byte_sel) begin
            nxt_h = h_cnt + 10'd1;
        end
    end

    assign nxt_active = (nxt_state == ST_ACTIVE) && ({1'b0, nxt_h} < H_ACT);
    assign lfsr_seed  = pclk && start_frame;
    assign lfsr_step  = pclk && nxt_active && nxt_byte;

    ov_7670_pattern_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .SOLID_COLOR (SOLID_COLOR)
    ) u_pattern (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel_q),
        .h_cnt     (nxt_h),
        .line      (nxt_v),
        .seed_load (lfsr_seed),
        .step      (lfsr_step),
        .pixel     (pixel)
    );

    // pclk doubles as the byte-slot phase; slot state advances at the end of phase 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk       <= 1'b0;
            state      <= ST_IDLE;
            byte_sel   <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            sel_q      <= PAT_BARS;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            pclk       <= ~pclk;
            frame_done <= 1'b0;
            if (pclk) begin
                state    <= nxt_state;
                byte_sel <= nxt_byte;
                h_cnt    <= nxt_h;
                v_cnt    <= nxt_v;
                if (start_frame) begin
                    sel_q <= pattern_sel;
                end
                vsync <= (nxt_state == ST_VSYNC);
                href  <= nxt_active;
                if (nxt_active) begin
                    data <= nxt_byte ? pixel[7:0] : pixel[15:8];
                end else begin
                    data <= '0;
                end
            end else if (frame_end) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov_7670_stream_gen.sv
// Self-checking bench for ov_7670_stream_gen using a frame-time model (8/4/4/1/1/1 geometry).
// LFSR expectations follow OV7670_STREAM_GEN_LFSR_EN when it is defined for the build.
module tb_ov_7670_stream_gen;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LINE_CLK  = (HA + HB) * 4;
    localparam int FRAME_CLK = (VS + VB + VA + VF) * LINE_CLK;
    localparam logic [15:0] SOLID = 16'h07E0;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        pclk, vsync, href, frame_done;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [15:0] lseq [HA*VA];

    // Frame-time model state
    bit          m_run = 0;
    bit          m_pclk = 0;
    int          m_t = 0;
    int          m_sel = 0;
    logic [15:0] m_cnt = '0;
    int          vs_n, hr_n, hr_rise;
    bit          prev_href;

    ov_7670_stream_gen #(
        .H_ACTIVE    (HA),
        .H_BLANK     (HB),
        .V_ACTIVE    (VA),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF),
        .SOLID_COLOR (SOLID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input int sel, input int al, input int pix);
        logic [15:0] p;
        int bi;
        bi = pix / ((HA / 8 > 0) ? HA / 8 : 1);
        if (bi > 7) bi = 7;
        case (sel)
            0: p = bars[bi];
            1: p = {al[7:0], pix[7:0]};
            2: p = SOLID;
`ifdef OV7670_STREAM_GEN_LFSR_EN
            default: p = lseq[al * HA + pix];
`else
            default: p = SOLID;
`endif
        endcase
        return p;
    endfunction

    // LFSR sequence from the polynomial: bits for x^14, x^13, x^11 plus feedback into bit 15.
    initial begin
        logic [15:0] s;
        bit lsb;
        s = 16'hACE1;
        for (int k = 0; k < HA * VA; k++) begin
            lseq[k] = s;
            lsb = s[0];
            s = s >> 1;
            if (lsb) s = s ^ (16'h8000 | 16'h2000 | 16'h1000 | 16'h0400);
        end
    end

    // Per-cycle compare against the model
    initial begin
        bit prev;
        int ln, p, pix, byt, al;
        bit e_vs, e_hr, e_fd;
        logic [7:0] e_d;
        logic [15:0] px;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_run = 0; m_pclk = 0; m_cnt = '0; m_t = 0;
            end else begin
                prev = m_pclk;
                m_pclk = ~m_pclk;
                if (m_run) begin
                    m_t++;
                    if (m_t == FRAME_CLK) begin
                        if (enable) begin m_t = 0; m_sel = int'(pattern_sel); end
                        else m_run = 0;
                    end
                end else if (prev && enable) begin
                    m_run = 1; m_t = 0; m_sel = int'(pattern_sel);
                end
                if (m_run && m_t == FRAME_CLK - 1) m_cnt++;
            end
            e_vs = 0; e_hr = 0; e_d = '0; e_fd = 0;
            if (m_run) begin
                ln  = m_t / LINE_CLK;
                p   = m_t % LINE_CLK;
                pix = p / 4;
                byt = (p / 2) % 2;
                al  = ln - (VS + VB);
                e_vs = (ln < VS);
                e_hr = (al >= 0) && (al < VA) && (pix < HA);
                if (e_hr) begin
                    px = exp_pixel(m_sel, al, pix);
                    e_d = byt ? px[7:0] : px[15:8];
                end
                e_fd = (m_t == FRAME_CLK - 1);
            end
            chk("pclk", {31'd0, pclk}, {31'd0, m_pclk});
            chk("vsync", {31'd0, vsync}, {31'd0, e_vs});
            chk("href", {31'd0, href}, {31'd0, e_hr});
            chk("data", {24'd0, data}, {24'd0, e_d});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});

            if (m_run) begin
                if (m_t == 0) begin vs_n = 0; hr_n = 0; hr_rise = 0; prev_href = 0; end
                vs_n += int'(vsync);
                hr_n += int'(href);
                if (href && !prev_href) hr_rise++;
                prev_href = href;
                if (m_t == FRAME_CLK - 1) begin
                    chk("vsync_clk_count", vs_n, 48);
                    chk("href_clk_count", hr_n, 128);
                    chk("href_pulses", hr_rise, 4);
                end
                case (m_sel)
                    0: case (m_t)
                        97:  chk("bar_p0_b0", {24'd0, data}, 32'hFF);
                        99:  chk("bar_p0_b1", {24'd0, data}, 32'hFF);
                        117: chk("bar_p5_b0", {24'd0, data}, 32'hF8);
                        119: chk("bar_p5_b1", {24'd0, data}, 32'h00);
                        125: chk("bar_p7_b0", {24'd0, data}, 32'h00);
                        127: chk("bar_p7_b1", {24'd0, data}, 32'h00);
                        default: ;
                    endcase
                    1: case (m_t)
                        205: chk("coord_l2p3_b0", {24'd0, data}, 32'h02);
                        207: chk("coord_l2p3_b1", {24'd0, data}, 32'h03);
                        default: ;
                    endcase
                    2: case (m_t)
                        97: chk("solid_b0", {24'd0, data}, 32'h07);
                        99: chk("solid_b1", {24'd0, data}, 32'hE0);
                        default: ;
                    endcase
                    default: case (m_t)
`ifdef OV7670_STREAM_GEN_LFSR_EN
                        97:  chk("lfsr_p0_b0", {24'd0, data}, 32'hAC);
                        99:  chk("lfsr_p0_b1", {24'd0, data}, 32'hE1);
                        101: chk("lfsr_p1_b0", {24'd0, data}, 32'hE2);
`else
                        97:  chk("sel3_p0_b0", {24'd0, data}, 32'h07);
                        99:  chk("sel3_p0_b1", {24'd0, data}, 32'hE0);
                        101: chk("sel3_p1_b0", {24'd0, data}, 32'h07);
`endif
                        default: ;
                    endcase
                endcase
            end
        end
    end

    task automatic wait_t(input int tt);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_run && m_t == tt) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL wait_t: frame time %0d not reached within 2000 clk", tt);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_vsync", {31'd0, vsync}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Pattern sequence: coord, bars, lfsr x2, solid; then enable drop mid-ACTIVE
        enable = 1'b1;
        pattern_sel = 2'd1;
        wait_t(100);
        pattern_sel = 2'd0;
        wait_t(100);
        pattern_sel = 2'd3;
        wait_t(100);
        wait_t(100);
        pattern_sel = 2'd2;
        wait_t(100);
        wait_t(150);
        enable = 1'b0;
        repeat (400) @(negedge clk);
        chk("frame_cnt_after_5", {16'd0, frame_cnt}, 32'd5);
        chk("idle_vsync", {31'd0, vsync}, 32'd0);
        chk("idle_href", {31'd0, href}, 32'd0);

        // Fresh start, drop enable mid-ACTIVE
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd1;
        wait_t(150);
        enable = 1'b0;
        repeat (400) @(negedge clk);
        chk("frame_cnt_after_drop", {16'd0, frame_cnt}, 32'd1);

        // Reset mid-ACTIVE, then restart from VSYNC
        enable = 1'b1;
        pattern_sel = 2'd0;
        wait_t(150);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_pclk", {31'd0, pclk}, 32'd0);
        chk("midreset_vsync", {31'd0, vsync}, 32'd0);
        chk("midreset_href", {31'd0, href}, 32'd0);
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reset = 1'b0;
        wait_t(100);
        wait_t(FRAME_CLK - 1);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
